// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared encodings for the multi-cycle MIPS control path
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [5:0] OP_R     = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_RTYPE = 4'b0010;
  localparam logic [3:0] ALU_SLT   = 4'b0100;
  localparam logic [3:0] ALU_ANDU  = 4'b1011;
  localparam logic [3:0] ALU_SLTU  = 4'b1100;
  localparam logic [3:0] ALU_ADDIU = 4'b1101;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_REG   = 2'b01;
  localparam logic [1:0] SRCA_SHAMT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MDR = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_REG    = 2'b11;

  // link covers jal and jalr; the opcode tells them apart
  typedef struct packed {
    logic load;
    logic store;
    logic r_alu;
    logic i_arith;
    logic branch;
    logic jump;
    logic jump_reg;
    logic link;
    logic illegal;
  } inst_class_t;

  function automatic logic is_shift(input logic [5:0] funct);
    return (funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA);
  endfunction

  function automatic logic is_r_alu_funct(input logic [5:0] funct);
    return is_shift(funct) || (funct inside {[6'h20:6'h27], 6'h2a, 6'h2b});
  endfunction

endpackage

// File: rtl/inst_class_decode.sv
// rtl/inst_class_decode.sv - one-hot instruction class from OpCode/Funct
// bne (0x05) is legal only when BNE_EN is defined.
module inst_class_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  output inst_class_t cls
);

  always_comb begin
    cls = '0;
    case (opcode)
      OP_R: begin
        if (funct == FN_JR)             cls.jump_reg = 1'b1;
        else if (funct == FN_JALR)      cls.link     = 1'b1;
        else if (is_r_alu_funct(funct)) cls.r_alu    = 1'b1;
        else                            cls.illegal  = 1'b1;
      end
      OP_LW:   cls.load  = 1'b1;
      OP_SW:   cls.store = 1'b1;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_LUI: cls.i_arith = 1'b1;
      OP_BEQ:  cls.branch = 1'b1;
`ifdef BNE_EN
      OP_BNE:  cls.branch = 1'b1;
`endif
      OP_J:    cls.jump = 1'b1;
      OP_JAL:  cls.link = 1'b1;
      default: cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl_fsm.sv
// rtl/multi_cycle_ctrl_fsm.sv - multi-cycle MIPS main control sequencer
// Optional bne support under macro BNE_EN.
module multi_cycle_ctrl_fsm
  import cpu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       BranchNe,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUOp,
  output logic       ExtOp,
  output logic       LuiOp,
  output logic [1:0] PCSource
);

  state_t      state, state_next;
  inst_class_t cls;

  // branch resolution happens in the datapath from PCWriteCond/BranchNe
  logic zero_unused;
  assign zero_unused = Zero;

  inst_class_decode u_decode (
    .opcode (OpCode),
    .funct  (Funct),
    .cls    (cls)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IF;
    else       state <= state_next;
  end

  always_comb begin
    state_next = S_IF;
    case (state)
      S_IF:  state_next = MemReady ? S_ID : S_IF;
      S_ID:  state_next = cls.illegal ? S_IF : S_EX;
      S_EX: begin
        if (cls.load || cls.store)         state_next = S_MEM;
        else if (cls.r_alu || cls.i_arith) state_next = S_WB;
        else                               state_next = S_IF;
      end
      S_MEM: begin
        if (!MemReady)     state_next = S_MEM;
        else if (cls.load) state_next = S_WB;
        else               state_next = S_IF;
      end
      default: state_next = S_IF;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    BranchNe    = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = DST_RT;
    MemtoReg    = M2R_ALU;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_REG;
    ALUOp       = ALU_ADD;
    ExtOp       = 1'b0;
    LuiOp       = 1'b0;
    PCSource    = PCS_ALU;
    if (!reset) begin
      case (state)
        S_IF: begin
          MemRead = 1'b1;
          ALUSrcB = SRCB_FOUR;
          IRWrite = MemReady;
          PCWrite = MemReady;
        end
        S_ID: begin
          ALUSrcB = SRCB_IMM_SH;
          ExtOp   = 1'b1;
        end
        S_EX: begin
          if (cls.load || cls.store || cls.i_arith) begin
            ALUSrcA = SRCA_REG;
            ALUSrcB = SRCB_IMM;
            ExtOp   = 1'b1;
            case (OpCode)
              OP_ADDIU: ALUOp = ALU_ADDIU;
              OP_SLTI:  ALUOp = ALU_SLT;
              OP_SLTIU: ALUOp = ALU_SLTU;
              OP_ANDI: begin
                ALUOp = ALU_ANDU;
                ExtOp = 1'b0;
              end
              OP_LUI: begin
                LuiOp = 1'b1;
                ExtOp = 1'b0;
              end
              default: ALUOp = ALU_ADD;
            endcase
          end
          if (cls.r_alu) begin
            ALUSrcA = is_shift(Funct) ? SRCA_SHAMT : SRCA_REG;
            ALUOp   = ALU_RTYPE;
          end
          if (cls.branch) begin
            ALUSrcA     = SRCA_REG;
            ALUOp       = ALU_SUB;
            PCWriteCond = 1'b1;
            PCSource    = PCS_ALUOUT;
`ifdef BNE_EN
            BranchNe    = (OpCode == OP_BNE);
`endif
          end
          if (cls.jump || cls.jump_reg || cls.link) begin
            PCWrite  = 1'b1;
            PCSource = (OpCode == OP_R) ? PCS_REG : PCS_JUMP;
          end
          if (cls.link) begin
            RegWrite = 1'b1;
            RegDst   = (OpCode == OP_R) ? DST_RD : DST_RA;
            MemtoReg = M2R_PC;
          end
        end
        S_MEM: begin
          IorD     = 1'b1;
          MemRead  = cls.load;
          MemWrite = cls.store;
        end
        S_WB: begin
          RegWrite = 1'b1;
          if (cls.load)  MemtoReg = M2R_MDR;
          if (cls.r_alu) RegDst   = DST_RD;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_ctrl_fsm.sv
// tb/tb_multi_cycle_ctrl_fsm.sv - self-checking bench for multi_cycle_ctrl_fsm
module tb_multi_cycle_ctrl_fsm;

  typedef struct packed {
    logic       pcwrite, pcwritecond, branchne, iord, memread, memwrite, irwrite, regwrite;
    logic [1:0] regdst, memtoreg, srca, srcb;
    logic [3:0] aluop;
    logic       extop, luiop;
    logic [1:0] pcsource;
  } out_t;

  typedef enum {PH_RST, PH_IF, PH_ID, PH_EX, PH_MEM, PH_WB} ph_e;

  logic       clk = 1'b0;
  logic       reset, Zero, MemReady;
  logic [5:0] OpCode, Funct;
  logic       PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite, RegWrite;
  logic [1:0] RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource;
  logic [3:0] ALUOp;
  logic       ExtOp, LuiOp;

  int checks = 0;
  int errors = 0;
  out_t  exp_q[$];
  string tag_q[$];
  out_t  act;

  multi_cycle_ctrl_fsm dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNe(BranchNe), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .ExtOp(ExtOp), .LuiOp(LuiOp), .PCSource(PCSource)
  );

  always #5 clk = ~clk;

  assign act = '{pcwrite: PCWrite, pcwritecond: PCWriteCond, branchne: BranchNe, iord: IorD,
                 memread: MemRead, memwrite: MemWrite, irwrite: IRWrite, regwrite: RegWrite,
                 regdst: RegDst, memtoreg: MemtoReg, srca: ALUSrcA, srcb: ALUSrcB,
                 aluop: ALUOp, extop: ExtOp, luiop: LuiOp, pcsource: PCSource};

  // Instruction knowledge straight from the ISA table
  function automatic logic bne_on();
`ifdef BNE_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic r_legal(input logic [5:0] fn);
    return fn inside {6'h00, 6'h02, 6'h03, 6'h08, 6'h09, [6'h20:6'h27], 6'h2a, 6'h2b};
  endfunction

  function automatic logic legal(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) return r_legal(fn);
    if (op == 6'h05) return bne_on();
    return op inside {6'h02, 6'h03, 6'h04, 6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0f, 6'h23, 6'h2b};
  endfunction

  function automatic logic arith_i(input logic [5:0] op);
    return op inside {6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0f};
  endfunction

  function automatic logic alu_r(input logic [5:0] op, input logic [5:0] fn);
    return (op == 6'h00) && r_legal(fn) && !(fn inside {6'h08, 6'h09});
  endfunction

  function automatic out_t spec_out(input ph_e ph, input logic [5:0] op, input logic [5:0] fn,
                                    input logic rdy);
    out_t o = '0;
    case (ph)
      PH_IF: begin
        o.memread = 1; o.srcb = 2'b01; o.irwrite = rdy; o.pcwrite = rdy;
      end
      PH_ID: begin
        o.srcb = 2'b11; o.extop = 1;
      end
      PH_EX: begin
        if (op inside {6'h23, 6'h2b} || arith_i(op)) begin
          o.srca = 2'b01; o.srcb = 2'b10; o.extop = 1;
          if (op == 6'h09) o.aluop = 4'b1101;
          if (op == 6'h0a) o.aluop = 4'b0100;
          if (op == 6'h0b) o.aluop = 4'b1100;
          if (op == 6'h0c) begin o.aluop = 4'b1011; o.extop = 0; end
          if (op == 6'h0f) begin o.luiop = 1; o.extop = 0; end
        end else if (alu_r(op, fn)) begin
          o.aluop = 4'b0010;
          o.srca  = (fn inside {6'h00, 6'h02, 6'h03}) ? 2'b10 : 2'b01;
        end else if (op == 6'h04 || op == 6'h05) begin
          o.srca = 2'b01; o.aluop = 4'b0001; o.pcwritecond = 1; o.pcsource = 2'b01;
          o.branchne = (op == 6'h05);
        end else if (op == 6'h02 || op == 6'h03) begin
          o.pcwrite = 1; o.pcsource = 2'b10;
          if (op == 6'h03) begin o.regwrite = 1; o.regdst = 2'b10; o.memtoreg = 2'b10; end
        end else if (op == 6'h00) begin
          o.pcwrite = 1; o.pcsource = 2'b11;
          if (fn == 6'h09) begin o.regwrite = 1; o.regdst = 2'b01; o.memtoreg = 2'b10; end
        end
      end
      PH_MEM: begin
        o.iord = 1; o.memread = (op == 6'h23); o.memwrite = (op == 6'h2b);
      end
      PH_WB: begin
        o.regwrite = 1;
        if (op == 6'h23) o.memtoreg = 2'b01;
        if (op == 6'h00) o.regdst = 2'b01;
      end
      default: ;
    endcase
    return o;
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      out_t  e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got %h want %h", t, act, e);
      end
    end
  end

  task automatic step(input string tag, input ph_e ph, input logic [5:0] op, input logic [5:0] fn,
                      input logic rdy, input logic rst);
    @(posedge clk);
    #1;
    reset = rst; MemReady = rdy; OpCode = op; Funct = fn; Zero = (op == 6'h04);
    exp_q.push_back(spec_out(ph, op, fn, rdy));
    tag_q.push_back(tag);
  endtask

  task automatic pin(input string tag, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s cycles: got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input int if_stalls, input int mem_stalls, input int want_cycles);
    int n = 0;
    repeat (if_stalls) begin step({tag, " IF"}, PH_IF, op, fn, 0, 0); n++; end
    step({tag, " IF"}, PH_IF, op, fn, 1, 0); n++;
    step({tag, " ID"}, PH_ID, op, fn, 1, 0); n++;
    if (legal(op, fn)) begin
      step({tag, " EX"}, PH_EX, op, fn, 1, 0); n++;
      if (op == 6'h23 || op == 6'h2b) begin
        repeat (mem_stalls) begin step({tag, " MEM"}, PH_MEM, op, fn, 0, 0); n++; end
        step({tag, " MEM"}, PH_MEM, op, fn, 1, 0); n++;
      end
      if (op == 6'h23 || alu_r(op, fn) || arith_i(op)) begin
        step({tag, " WB"}, PH_WB, op, fn, 1, 0); n++;
      end
    end
    pin(tag, n, want_cycles);
  endtask

  initial begin
    reset = 1; MemReady = 0; OpCode = 0; Funct = 0; Zero = 0;
    step("reset0", PH_RST, 6'h00, 6'h00, 0, 1);
    step("reset1", PH_RST, 6'h00, 6'h00, 1, 1);
    run_instr("add",      6'h00, 6'h20, 0, 0, 4);
    run_instr("lw_stall", 6'h23, 6'h05, 0, 2, 7);
    run_instr("sw",       6'h2b, 6'h00, 0, 0, 4);
    run_instr("beq",      6'h04, 6'h03, 0, 0, 3);
    run_instr("sltiu",    6'h0b, 6'h01, 0, 0, 4);
    run_instr("slti",     6'h0a, 6'h01, 0, 0, 4);
    run_instr("addi",     6'h08, 6'h00, 0, 0, 4);
    run_instr("addiu",    6'h09, 6'h00, 0, 0, 4);
    run_instr("andi",     6'h0c, 6'h00, 0, 0, 4);
    run_instr("lui",      6'h0f, 6'h00, 0, 0, 4);
    run_instr("j",        6'h02, 6'h00, 0, 0, 3);
    run_instr("jal",      6'h03, 6'h10, 0, 0, 3);
    run_instr("jr",       6'h00, 6'h08, 0, 0, 3);
    run_instr("jalr",     6'h00, 6'h09, 0, 0, 3);
    run_instr("sll",      6'h00, 6'h00, 0, 0, 4);
    run_instr("illegal",  6'h3f, 6'h00, 0, 0, 2);
    run_instr("bad_fn",   6'h00, 6'h3f, 0, 0, 2);
    run_instr("bne",      6'h14 >> 2, 6'h03, 0, 0, bne_on() ? 3 : 2);
    run_instr("lw_ifst",  6'h23, 6'h00, 1, 0, 6);
    // reset while sw waits in MEM
    step("rst_sw IF",  PH_IF,  6'h2b, 6'h00, 1, 0);
    step("rst_sw ID",  PH_ID,  6'h2b, 6'h00, 1, 0);
    step("rst_sw EX",  PH_EX,  6'h2b, 6'h00, 1, 0);
    step("rst_sw MEM", PH_MEM, 6'h2b, 6'h00, 0, 0);
    step("rst_sw RST", PH_RST, 6'h2b, 6'h00, 0, 1);
    run_instr("post_rst", 6'h00, 6'h22, 2, 0, 6);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_cycle_ctrl_fsm.md
# multi_cycle_ctrl_fsm

Main sequencer for the multi-cycle MIPS CPU.
- Steps each instruction through fetch, decode, execute, memory and writeback states.
- Drives the register-file, memory, PC and mux controls.
- Issues the 4-bit ALUOp consumed by the ALU control decoder.
- Sits between the instruction register (opcode/funct fields) and the shared ALU/memory datapath.
- Stalls on a memory-ready handshake.

## Interface
Parameters:
- None.

Ports (name, direction, width, meaning):
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- OpCode  in  6  IR[31:26].
- Funct  in  6  IR[5:0].
- Zero  in  1  ALU zero flag.
- MemReady  in  1  memory completes the current access this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load if branch condition holds.
- BranchNe  out  1  inverts the branch condition (see Configuration).
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction register load.
- RegWrite  out  1  register file write enable.
- RegDst  out  2  write register select: 00 = rt, 01 = rd, 10 = $31.
- MemtoReg  out  2  write data select: 00 = ALUOut, 01 = MDR, 10 = PC.
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = reg A, 10 = shamt.
- ALUSrcB  out  2  ALU B select: 00 = reg B, 01 = 4, 10 = ext imm, 11 = ext imm<<2.
- ALUOp  out  4  ALU operation. [3] = 1 means unsigned. [2:0] = 000 add, 001 sub, 010 R-type (by funct), 011 and, 100 slt, 101 addiu.
- ExtOp  out  1  immediate extension: 1 = sign-extend, 0 = zero-extend.
- LuiOp  out  1  immediate << 16.
- PCSource  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = reg A.

## Operation
State register: 3 bits. States are IF=0, ID=1, EX=2, MEM=3, WB=4.

Reset behaviour:
- While reset is high, the next state is IF.
- All write/strobe outputs (PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite) are forced 0. All mux selects are 0.

Outputs are decoded combinationally from the state plus OpCode/Funct (Moore with field decode). Any output not listed for a state is 0.

- **IF:**
  - Outputs: MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=01, ALUOp=0000, PCSource=00.
  - IRWrite and PCWrite follow MemReady.
  - Stay in IF while MemReady=0; go to ID when MemReady=1.
- **ID:**
  - Outputs: ALUSrcA=00, ALUSrcB=11, ExtOp=1, ALUOp=0000 (branch target into ALUOut).
  - Legal opcode → EX. Illegal opcode or R-type funct → IF, with no writes.
- **EX:**
  - lw/sw/addi: ALUSrcA=01, ALUSrcB=10, ExtOp=1, ALUOp=0000.
  - addiu: same sources, ALUOp=1101.
  - slti: ALUOp=0100. sltiu: ALUOp=1100.
  - andi: ExtOp=0, ALUOp=1011.
  - lui: ALUOp=0000, LuiOp=1.
  - R-type: ALUSrcB=00, ALUOp=0010. ALUSrcA=10 for sll/srl/sra (funct 00/02/03), otherwise 01.
  - beq: ALUSrcA=01, ALUSrcB=00, ALUOp=0001, PCWriteCond=1, PCSource=01.
  - j: PCWrite=1, PCSource=10.
  - jal: as j, plus RegWrite=1, RegDst=10, MemtoReg=10.
  - jr: PCWrite=1, PCSource=11.
  - jalr: as jr, plus RegWrite=1, RegDst=01, MemtoReg=10.
  - Next state: lw/sw → MEM; R-type ALU ops and I-type arithmetic (including lui) → WB; branch/jump → IF.
- **MEM:**
  - Outputs: IorD=1. MemRead=1 for lw; MemWrite=1 for sw.
  - Strobes are held until MemReady=1.
  - Then lw → WB, sw → IF.
- **WB:**
  - Outputs: RegWrite=1, for exactly one cycle.
  - lw: RegDst=00, MemtoReg=01.
  - R-type: RegDst=01, MemtoReg=00.
  - I-type arithmetic: RegDst=00, MemtoReg=00.
  - Next state: IF.

Boundary rules:
- A write to $0 is not suppressed here; the register file handles it.
- Zero is sampled only in the EX cycle of a branch.
- A reset asserted in any state takes effect in that cycle: strobes go to 0 and the state is IF on the next edge.

## Timing
With MemReady tied to 1, cycles per instruction are:
- lw: 5.
- sw, R-type, I-type arithmetic, lui: 4.
- beq, j, jal, jr, jalr: 3.

Further rules:
- Each MemReady=0 cycle in IF or MEM adds exactly one cycle.
- The first fetch occurs in the first cycle after reset deasserts.
- PC and IR update on the same edge that ends IF.

## Configuration
Macro: BNE_EN.
- **Defined:** opcode 0x05 (bne) is legal. In EX it drives the same outputs as beq plus BranchNe=1; the datapath then loads PC when Zero=0.
- **Undefined:** 0x05 is illegal (ID → IF, no writes) and BranchNe is constant 0.

## Structure
Shared package `cpu_ctrl_pkg` holds:
- State encodings.
- Opcode constants: lw 23, sw 2b, lui 0f, addi 08, addiu 09, andi 0c, slti 0a, sltiu 0b, beq 04, bne 05, j 02, jal 03, R 00.
- Funct constants: jr 08, jalr 09, sll 00, srl 02, sra 03.
- ALUOp and mux-select codes.

One sub-module, `inst_class_decode`, is combinational. It maps OpCode/Funct to a one-hot class: load, store, r_alu, i_arith, branch, jump, jump_reg, link, illegal.

## Test plan
- **Reset mid-MEM:** reset during sw MEM with MemReady=0 → MemWrite=0 that cycle; the next state is IF; PCWrite=0 until a fetch completes.
- **add $3,$1,$2 (0x00221820):** IF→ID→EX→WB in 4 cycles; EX shows ALUOp=0010, ALUSrcA=01; WB shows RegWrite=1, RegDst=01 for exactly one cycle.
- **lw with MemReady low:** MemReady=0 for 2 cycles in MEM → MemRead and IorD held for 3 cycles; total 7 cycles; WB has MemtoReg=01.
- **beq:** Zero=1 in EX → PCWriteCond=1, PCSource=01; returns to IF after 3 cycles. sltiu in EX → ALUOp=1100.
- **jal (0x0C000010):** EX shows PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=10. Illegal opcode 0x3f → ID→IF with no strobe asserted.
- **bne (0x14220003):** with BNE_EN → BranchNe=1 in EX. Without BNE_EN → treated as illegal.
